// File: rtl/uart_baud_tx.sv
// UART transmit stage: serialises one word per valid/ready handshake into a
// start/data/parity/stop frame whose bit boundaries follow rising edges of baud_clk.
//
//   state  | meaning
//   IDLE   | line high, ready for a new word
//   WAIT   | word latched, waiting for the next baud edge to begin the start bit
//   START  | start bit (0) on the line
//   DATA   | data bits on the line, LSB first
//   PARITY | parity bit on the line
//   STOP   | stop bit period(s) on the line
module uart_baud_tx #(
  parameter int DataBits = 8,
  parameter int Parity   = 0,
  parameter int StopBits = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_clk,
  input  logic [DataBits-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                txd,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] DATA_BITS_W = 4'(DataBits);
  localparam logic [1:0] STOP_BITS_W = 2'(StopBits);

  state_t              state, state_d;
  logic [DataBits-1:0] shift, shift_d;
  logic [3:0]          bit_cnt, bit_cnt_d;
  logic [1:0]          stop_cnt, stop_cnt_d;
  logic                par_q, par_d;
  logic                txd_q, txd_d;
  logic                done_q, done_d;
  logic                baud_q;
  logic                strobe;

  assign strobe   = baud_clk & ~baud_q;
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign txd      = txd_q;
  assign done     = done_q;

  // baud_q resets high so a baud_clk already high at release is not seen as an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
      baud_q   <= 1'b1;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
      baud_q   <= baud_clk;
    end
  end

  always_comb begin
    state_d    = state;
    shift_d    = shift;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    par_d      = par_q;
    txd_d      = txd_q;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        // a strobe landing in the accept cycle is deliberately not acted on
        if (in_valid) begin
          shift_d    = in_data;
          par_d      = (Parity == 2) ? ~(^in_data) : ^in_data;
          bit_cnt_d  = '0;
          stop_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (strobe) begin
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (strobe) begin
          txd_d     = shift[0];
          shift_d   = shift >> 1;
          bit_cnt_d = 4'd1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (strobe) begin
          if (bit_cnt < DATA_BITS_W) begin
            txd_d     = shift[0];
            shift_d   = shift >> 1;
            bit_cnt_d = bit_cnt + 4'd1;
          end else if (Parity != 0) begin
            txd_d   = par_q;
            state_d = PARITY;
          end else begin
            txd_d      = 1'b1;
            stop_cnt_d = 2'd1;
            state_d    = STOP;
          end
        end
      end
      PARITY: begin
        if (strobe) begin
          txd_d      = 1'b1;
          stop_cnt_d = 2'd1;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          if (stop_cnt < STOP_BITS_W) begin
            stop_cnt_d = stop_cnt + 2'd1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_baud_tx.sv
// Bench for uart_baud_tx: three instances (no parity / even+2 stop / odd) share
// clock, baud reference, reset and data; each has its own in_valid.
module tb_uart_baud_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_clk;
  logic [7:0] data;
  logic [2:0] valid_s, rdy_s, txd_s, busy_s, done_s;
  logic       baud_run;
  int         bcnt;
  int         tests  = 0;
  int         failed = 0;
  int         done_cnt [3];

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] word;
    int         nbits;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  uart_baud_tx #(.DataBits(8), .Parity(0), .StopBits(1)) u_none (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .in_data(data), .in_valid(valid_s[0]),
    .in_ready(rdy_s[0]), .txd(txd_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  uart_baud_tx #(.DataBits(8), .Parity(1), .StopBits(2)) u_even (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .in_data(data), .in_valid(valid_s[1]),
    .in_ready(rdy_s[1]), .txd(txd_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  uart_baud_tx #(.DataBits(8), .Parity(2), .StopBits(1)) u_odd (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .in_data(data), .in_valid(valid_s[2]),
    .in_ready(rdy_s[2]), .txd(txd_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  // baud reference: 16 clk period, high for the first 8 clks of each period
  initial begin
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (baud_run) begin
        bcnt     = (bcnt + 1) % 16;
        baud_clk = (bcnt < 8);
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) done_cnt[k] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) if (done_s[k]) done_cnt[k]++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int sel, input logic [7:0] word, input string nm);
    @(negedge clk);
    data         = word;
    valid_s[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_s[sel] = 1'b0;
    chk({nm, "_accept_busy"}, 32'(busy_s[sel]), 32'd1);
  endtask

  task automatic wait_fall(input int sel, input string nm, output bit ok);
    int t = 0;
    while (txd_s[sel] !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 200);
    if (!ok) chk({nm, "_start_timeout"}, 32'(txd_s[sel]), 32'd0);
  endtask

  task automatic check_frame(input int sel, input logic [11:0] exp, input int n, input string nm);
    bit ok;
    int t;
    int d0 = done_cnt[sel];
    wait_fall(sel, nm, ok);
    if (!ok) return;
    for (int i = 0; i < n; i++) begin
      repeat (8) @(negedge clk);
      chk($sformatf("%s_bit%0d", nm, i), 32'(txd_s[sel]), 32'(exp[i]));
      if (i < n - 1) repeat (8) @(negedge clk);
    end
    t = 0;
    while (done_s[sel] !== 1'b1 && t < 24) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_done_seen"}, 32'(done_s[sel]), 32'd1);
    chk({nm, "_ready_at_done"}, 32'(rdy_s[sel]), 32'd1);
    chk({nm, "_done_count"}, 32'(done_cnt[sel] - d0), 32'd1);
  endtask

  initial begin
    bit ok;
    int c;
    int d0;

    vecs[0] = '{"none_a5", 0, 8'hA5, 10, 12'({1'b1, 8'hA5, 1'b0})};
    vecs[1] = '{"none_5a", 0, 8'h5A, 10, 12'({1'b1, 8'h5A, 1'b0})};
    vecs[2] = '{"even_07", 1, 8'h07, 12, {2'b11, 1'b1, 8'h07, 1'b0}};
    vecs[3] = '{"even_00", 1, 8'h00, 12, {2'b11, 1'b0, 8'h00, 1'b0}};
    vecs[4] = '{"even_80", 1, 8'h80, 12, {2'b11, 1'b1, 8'h80, 1'b0}};
    vecs[5] = '{"odd_07",  2, 8'h07, 11, 12'({1'b1, 1'b0, 8'h07, 1'b0})};
    vecs[6] = '{"odd_00",  2, 8'h00, 11, 12'({1'b1, 1'b1, 8'h00, 1'b0})};

    // reset with baud_clk held high
    rst      = 1'b0;
    baud_clk = 1'b1;
    baud_run = 1'b0;
    valid_s  = '0;
    data     = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd",   32'(txd_s),  32'h7);
    chk("rst_ready", 32'(rdy_s),  32'h7);
    chk("rst_busy",  32'(busy_s), 32'h0);
    chk("rst_done",  32'(done_s), 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_txd",  32'(txd_s),  32'h7);
    chk("idle_done", 32'(done_s), 32'h0);

    // baud_clk constant: word accepted but frame must not progress
    send(0, 8'hA5, "hold");
    repeat (40) @(negedge clk);
    chk("hold_txd",  32'(txd_s[0]),  32'd1);
    chk("hold_busy", 32'(busy_s[0]), 32'd1);
    baud_run = 1'b1;
    check_frame(0, vecs[0].exp, vecs[0].nbits, "first_a5");

    for (int v = 0; v < 7; v++) begin
      send(vecs[v].sel, vecs[v].word, vecs[v].name);
      check_frame(vecs[v].sel, vecs[v].exp, vecs[v].nbits, vecs[v].name);
    end

    // back-to-back with in_valid held, in_data changed while busy
    repeat (5) @(negedge clk);
    d0 = done_cnt[0];
    data       = 8'h01;
    valid_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_first_accept", 32'(busy_s[0]), 32'd1);
    data = 8'hFF;
    check_frame(0, 12'({1'b1, 8'h01, 1'b0}), 10, "b2b_first");
    @(negedge clk);
    chk("b2b_accept_next_clk", 32'(busy_s[0]), 32'd1);
    valid_s[0] = 1'b0;
    data       = 8'h00;
    check_frame(0, 12'({1'b1, 8'hFF, 1'b0}), 10, "b2b_second");
    repeat (40) @(negedge clk);
    chk("b2b_total_done", 32'(done_cnt[0] - d0), 32'd2);

    // accept in the same clk as a baud strobe
    c = 0;
    do begin
      @(posedge clk);
      c++;
    end while (bcnt != 15 && c < 40);
    @(negedge clk);
    data       = 8'h01;
    valid_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_s[0] = 1'b0;
    chk("coinc_accept", 32'(busy_s[0]), 32'd1);
    repeat (15) @(negedge clk);
    chk("coinc_line_high", 32'(txd_s[0]), 32'd1);
    @(negedge clk);
    chk("coinc_start_begins", 32'(txd_s[0]), 32'd0);
    c = 0;
    while (txd_s[0] === 1'b0 && c < 40) begin
      c++;
      @(negedge clk);
    end
    chk("coinc_start_len", 32'(c), 32'd16);
    c = 0;
    while (done_s[0] !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("coinc_done", 32'(done_s[0]), 32'd1);

    // reset during the start bit: line must go high without a clock edge
    repeat (3) @(negedge clk);
    d0 = done_cnt[0];
    send(0, 8'h3C, "rst_start");
    wait_fall(0, "rst_start", ok);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_start_txd_async", 32'(txd_s[0]), 32'd1);
    chk("rst_start_ready", 32'(rdy_s[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_start_no_done", 32'(done_cnt[0] - d0), 32'd0);

    // reset during data bit 3
    send(0, 8'h3C, "rst_bit3");
    wait_fall(0, "rst_bit3", ok);
    repeat (72) @(negedge clk);
    chk("rst_bit3_line", 32'(txd_s[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_bit3_txd", 32'(txd_s[0]), 32'd1);
    chk("rst_bit3_busy", 32'(busy_s[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_bit3_no_done", 32'(done_cnt[0] - d0), 32'd0);
    chk("rst_bit3_idle_txd", 32'(txd_s[0]), 32'd1);

    send(0, 8'h3C, "resend_3c");
    check_frame(0, 12'({1'b1, 8'h3C, 1'b0}), 10, "resend_3c");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
